// File: rtl/alu_mul_sequencer_if.sv
// Issue-side and ALU-side signal bundle for alu_mul_sequencer.
// slave = the sequencer; master = the requester plus the ALU/arbiter.
interface alu_mul_sequencer_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             alu_req;
  logic             alu_gnt;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_sum_sub;
  logic [WIDTH-1:0] alu_result;

  modport slave (
    input  start, op_a, op_b, alu_gnt, alu_result,
    output ready, busy, done, result, alu_req, alu_a, alu_b, alu_sum_sub
  );

  modport master (
    output start, op_a, op_b, alu_gnt, alu_result,
    input  ready, busy, done, result, alu_req, alu_a, alu_b, alu_sum_sub
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier sequencer that borrows the shared ALU adder, one add per granted cycle.
// Optional macro MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module alu_mul_sequencer #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_mul_sequencer_if.slave   bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] result_r;

  logic [WIDTH-1:0] acc_next_s;
  logic             last_step_s;
  logic             early_exit_s;

  // Accumulator candidate for this step: take the adder output only when the multiplier bit is set.
  always_comb begin
    acc_next_s = acc_r;
    if (mplier_r[0]) begin
      acc_next_s = bus.alu_result;
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Step-count and early-termination conditions.
  always_comb begin
    last_step_s = (cnt_r == CNT_LAST);
`ifdef MUL_EARLY_EXIT_EN
    early_exit_s = (state_r == ST_RUN) && (mplier_r == {WIDTH{1'b0}});
`else
    early_exit_s = 1'b0;
`endif
  end

  // Control FSM and datapath registers; a low grant in RUN freezes everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      acc_r    <= {WIDTH{1'b0}};
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      result_r <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            acc_r    <= {WIDTH{1'b0}};
            mcand_r  <= bus.op_a;
            mplier_r <= bus.op_b;
            cnt_r    <= {CNT_W{1'b0}};
            state_r  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (early_exit_s) begin
            result_r <= acc_r;
            state_r  <= ST_DONE;
          end else if (bus.alu_gnt) begin
            acc_r    <= acc_next_s;
            mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            cnt_r    <= cnt_r + CNT_ONE;
            if (last_step_s) begin
              result_r <= acc_next_s;
              state_r  <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ready       = (state_r == ST_IDLE);
  assign bus.busy        = (state_r == ST_RUN);
  assign bus.done        = (state_r == ST_DONE);
  assign bus.alu_req     = (state_r == ST_RUN);
  assign bus.result      = result_r;
  assign bus.alu_a       = acc_r;
  assign bus.alu_b       = mcand_r;
  assign bus.alu_sum_sub = 1'b0;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed self-checking bench for alu_mul_sequencer; the bench plays the ALU (a+b, same cycle).
module tb_alu_mul_sequencer;

  localparam int W = 64;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  alu_mul_sequencer_if #(.WIDTH(W)) bus ();

  alu_mul_sequencer #(.WIDTH(W), .CNT_W(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.alu_result = bus.alu_a + bus.alu_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one edge (the start sample edge E0).
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    tick();
    bus.start = 1'b0;
  endtask

  // Advance until done is seen; lat counts edges since the call, -1 on timeout.
  task automatic wait_done(input int bound, output int lat, output int busy_cnt);
    lat      = -1;
    busy_cnt = bus.busy ? 1 : 0;
    for (int i = 1; i <= bound && lat < 0; i++) begin
      tick();
      if (bus.done) lat = i;
      else if (bus.busy) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %0b want 1", bus.ready); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got %0b want 0", bus.done); end
    checks++; if (bus.alu_req !== 1'b0) begin failures++; $display("FAIL reset_req got %0b want 0", bus.alu_req); end
    checks++; if (bus.result !== 64'd0) begin failures++; $display("FAIL reset_result got %0h want 0", bus.result); end
    checks++; if (bus.alu_a !== 64'd0 || bus.alu_b !== 64'd0) begin failures++; $display("FAIL reset_acc got %0h/%0h want 0/0", bus.alu_a, bus.alu_b); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat, bc;
    issue(64'd3, 64'd5);
    checks++; if (bus.alu_req !== 1'b1 || bus.alu_sum_sub !== 1'b0) begin failures++; $display("FAIL basic_req got req=%0b sub=%0b want 1/0", bus.alu_req, bus.alu_sum_sub); end
    checks++; if (bus.alu_a !== 64'd0 || bus.alu_b !== 64'd3) begin failures++; $display("FAIL basic_load got %0h/%0h want 0/3", bus.alu_a, bus.alu_b); end
    wait_done(200, lat, bc);
    checks++; if (lat !== 64) begin failures++; $display("FAIL basic_latency got %0d want 64", lat); end
    checks++; if (bc !== 64) begin failures++; $display("FAIL basic_busy_cycles got %0d want 64", bc); end
    checks++; if (bus.result !== 64'd15) begin failures++; $display("FAIL basic_result got %0h want f", bus.result); end
    tick();
    checks++; if (bus.done !== 1'b0 || bus.ready !== 1'b1) begin failures++; $display("FAIL basic_ready_after got done=%0b ready=%0b want 0/1", bus.done, bus.ready); end
  endtask

  task automatic test_wrap();
    int lat, bc;
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
    wait_done(200, lat, bc);
    checks++; if (bus.result !== 64'hFFFF_FFFF_FFFF_FFFE) begin failures++; $display("FAIL wrap_ones got %0h want fffffffffffffffe", bus.result); end
    tick();
    issue(64'h8000_0000_0000_0000, 64'd2);
    wait_done(200, lat, bc);
    checks++; if (bus.result !== 64'd0) begin failures++; $display("FAIL wrap_msb got %0h want 0", bus.result); end
    tick();
  endtask

  task automatic test_stall();
    int lat, bc;
    issue(64'd7, 64'd9);
    for (int i = 0; i < 5; i++) tick();
    bus.alu_gnt = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (bus.alu_a !== 64'd63 || bus.alu_b !== 64'd224) begin failures++; $display("FAIL stall_frozen got acc=%0d mcand=%0d want 63/224", bus.alu_a, bus.alu_b); end
    checks++; if (bus.alu_req !== 1'b1 || bus.busy !== 1'b1) begin failures++; $display("FAIL stall_req got req=%0b busy=%0b want 1/1", bus.alu_req, bus.busy); end
    bus.alu_gnt = 1'b1;
    wait_done(200, lat, bc);
    checks++; if (lat + 15 !== 74) begin failures++; $display("FAIL stall_latency got %0d want 74", lat + 15); end
    checks++; if (bus.result !== 64'd63) begin failures++; $display("FAIL stall_result got %0d want 63", bus.result); end
    tick();
  endtask

  task automatic test_ignore_start_and_reset();
    int lat, bc, dcnt;
    issue(64'd11, 64'd13);
    for (int i = 0; i < 5; i++) tick();
    issue(64'd1, 64'd1);
    wait_done(200, lat, bc);
    checks++; if (lat + 6 !== 64) begin failures++; $display("FAIL ignore_latency got %0d want 64", lat + 6); end
    checks++; if (bus.result !== 64'd143) begin failures++; $display("FAIL ignore_result got %0d want 143", bus.result); end
    tick();
    issue(64'd3, 64'd5);
    for (int i = 0; i < 20; i++) tick();
    reset = 1'b1;
    #1;
    checks++; if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.result !== 64'd0) begin failures++; $display("FAIL async_reset got ready=%0b busy=%0b result=%0h want 1/0/0", bus.ready, bus.busy, bus.result); end
    tick();
    reset = 1'b0;
    tick();
    checks++; if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.result !== 64'd0) begin failures++; $display("FAIL midrun_reset got ready=%0b busy=%0b result=%0h want 1/0/0", bus.ready, bus.busy, bus.result); end
    dcnt = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (bus.done) dcnt++;
    end
    checks++; if (dcnt !== 0) begin failures++; $display("FAIL reset_no_done got %0d want 0", dcnt); end
  endtask

  task automatic test_early_exit();
    int lat, bc, exp_zero, exp_six;
`ifdef MUL_EARLY_EXIT_EN
    exp_zero = 1;
    exp_six  = 3;
`else
    exp_zero = 64;
    exp_six  = 64;
`endif
    issue(64'd12345, 64'd0);
    wait_done(200, lat, bc);
    checks++; if (lat !== exp_zero) begin failures++; $display("FAIL exit_zero_latency got %0d want %0d", lat, exp_zero); end
    checks++; if (bus.result !== 64'd0) begin failures++; $display("FAIL exit_zero_result got %0h want 0", bus.result); end
    tick();
    issue(64'd6, 64'd3);
    wait_done(200, lat, bc);
    checks++; if (lat !== exp_six) begin failures++; $display("FAIL exit_six_latency got %0d want %0d", lat, exp_six); end
    checks++; if (bus.result !== 64'd18) begin failures++; $display("FAIL exit_six_result got %0d want 18", bus.result); end
    tick();
    issue(64'd1, 64'h8000_0000_0000_0000);
    wait_done(200, lat, bc);
    checks++; if (lat < 0 || bus.result !== 64'h8000_0000_0000_0000) begin failures++; $display("FAIL exit_msb_result got %0h lat=%0d want 8000000000000000", bus.result, lat); end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    issue(64'd5, 64'd6);
    wait_done(200, lat, bc);
    checks++; if (bus.result !== 64'd30) begin failures++; $display("FAIL b2b_first got %0d want 30", bus.result); end
    tick();
    checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got %0b want 1", bus.ready); end
    issue(64'd9, 64'd10);
    for (int i = 0; i < 30; i++) tick();
    checks++; if (bus.result !== 64'd30 || bus.busy !== 1'b1) begin failures++; $display("FAIL b2b_hold got %0d busy=%0b want 30/1", bus.result, bus.busy); end
    wait_done(200, lat, bc);
    checks++; if (lat + 30 !== 64) begin failures++; $display("FAIL b2b_latency got %0d want 64", lat + 30); end
    checks++; if (bus.result !== 64'd90) begin failures++; $display("FAIL b2b_second got %0d want 90", bus.result); end
    tick();
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.op_a    = 64'd0;
    bus.op_b    = 64'd0;
    bus.alu_gnt = 1'b1;
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_ignore_start_and_reset();
    test_early_exit();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
